// File: rtl/fetch_unit_if.sv
// Pipelined, in-order instruction-memory request/response bundle.
// master = fetch unit side, slave = memory side.
interface fetch_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     imem_req;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic                     imem_gnt;
  logic                     imem_rvalid;
  logic [DATA_WIDTH-1:0]    imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited imem requests, PC tag queue, prefetch queue to IF/ID.
// Optional macro FETCH_BYPASS_EN presents an arriving response directly when the queue is empty.
module fetch_unit #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter int                       FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_f,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  fetch_unit_if.master             imem,
  output logic [DATA_WIDTH-1:0]    instr_f,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  output logic                     valid_f,
  output logic                     fetch_busy
);
  localparam int                    PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                    CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]        DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);

  logic [ADDRESS_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, outst_q, outst_d, drop_q, drop_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [ADDRESS_WIDTH-1:0] tag_mem_q   [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem_q [FIFO_DEPTH];

  logic                     grant, rsp, push, pop, q_empty, byp_take;
  logic [ADDRESS_WIDTH-1:0] tag_head;
  logic [CNT_W:0]           credit;

  // Credit covers both buffered and in-flight words, so a response always finds room.
  assign credit         = {1'b0, cnt_q} + {1'b0, outst_q};
  assign imem.imem_req  = ~rst & ~pc_src_e & (credit < DEPTH_C);
  assign imem.imem_addr = fetch_addr_q;
  assign grant          = imem.imem_req & imem.imem_gnt;
  assign rsp            = imem.imem_rvalid;
  assign tag_head       = tag_mem_q[tag_rd_q];
  assign q_empty        = (cnt_q == '0);

`ifdef FETCH_BYPASS_EN
  logic byp_hit;
  assign byp_hit  = q_empty & (drop_q == '0) & rsp & ~pc_src_e;
  assign byp_take = byp_hit & ~stall_f;
`else
  assign byp_take = 1'b0;
`endif

  assign push = rsp & ~pc_src_e & (drop_q == '0) & ~byp_take;
  assign pop  = ~q_empty & ~stall_f;

  always_comb begin
    instr_f = NOP;
    pc_f    = '0;
    valid_f = 1'b0;
    if (!q_empty) begin
      instr_f = instr_mem_q[rd_ptr_q];
      pc_f    = pc_mem_q[rd_ptr_q];
      valid_f = 1'b1;
    end
`ifdef FETCH_BYPASS_EN
    else if (byp_hit) begin
      instr_f = imem.imem_rdata;
      pc_f    = tag_head;
      valid_f = 1'b1;
    end
`endif
  end

  assign pc_plus4_f = pc_f + ADDRESS_WIDTH'(4);
  assign fetch_busy = q_empty & ~valid_f;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    cnt_d        = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    outst_d      = outst_q + CNT_W'(grant) - CNT_W'(rsp);
    drop_d       = drop_q;
    // Tags retire on every response, stale or not, so they stay aligned with imem order.
    tag_wr_d     = tag_wr_q + PTR_W'(grant);
    tag_rd_d     = tag_rd_q + PTR_W'(rsp);
    if (pc_src_e) begin
      fetch_addr_d = pc_target_e;
      cnt_d        = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      drop_d       = outst_q - CNT_W'(rsp);
    end else begin
      if (grant) fetch_addr_d = fetch_addr_q + ADDRESS_WIDTH'(4);
      if (rsp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr_q <= RESET_PC;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      outst_q      <= '0;
      drop_q       <= '0;
      tag_rd_q     <= '0;
      tag_wr_q     <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      tag_rd_q     <= tag_rd_d;
      tag_wr_q     <= tag_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem_q[tag_wr_q] <= fetch_addr_q;
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= tag_head;
      instr_mem_q[wr_ptr_q] <= imem.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable in-order memory responder.
// Response data is the request address XOR 32'hA000_0000.
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_f, pc_f, pc_plus4_f;
  logic        valid_f, fetch_busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned lat   = 1;

  fetch_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) imem ();

  fetch_unit #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .pc_src_e(pc_src_e),
    .pc_target_e(pc_target_e), .imem(imem), .instr_f(instr_f), .pc_f(pc_f),
    .pc_plus4_f(pc_plus4_f), .valid_f(valid_f), .fetch_busy(fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mreq_t;

  mreq_t       mq[$];
  logic        nxt_v = 1'b0;
  logic [31:0] nxt_d = '0;

  initial begin
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;
  end

  // Grants are sampled late in the cycle; the response is presented from the next rising edge.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      mq.delete();
      nxt_v = 1'b0;
    end else begin
      if (imem.imem_req && imem.imem_gnt)
        mq.push_back('{addr: imem.imem_addr, due: cyc + lat});
      nxt_v = 1'b0;
      if (mq.size() != 0 && mq[0].due <= cyc + 1) begin
        nxt_v = 1'b1;
        nxt_d = mq[0].addr ^ 32'hA000_0000;
        void'(mq.pop_front());
      end
    end
  end

  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    imem.imem_rvalid = nxt_v;
    imem.imem_rdata  = nxt_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    imem.imem_gnt = 1'b0; lat = 1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   {31'b0, imem.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid_f}, 32'd0);
    chk("rst_instr", instr_f, 32'h0000_0013);
    chk("rst_pc",    pc_f, 32'h0);
    chk("rst_pc4",   pc_plus4_f, 32'h4);
    chk("rst_busy",  {31'b0, fetch_busy}, 32'd1);

    // Streaming with 1-cycle memory
    @(negedge clk); rst = 1'b0; imem.imem_gnt = 1'b1; #1;
    chk("c0_addr",  imem.imem_addr, 32'h0);
    chk("c0_req",   {31'b0, imem.imem_req}, 32'd1);
    chk("c0_valid", {31'b0, valid_f}, 32'd0);
    @(negedge clk); #1;
    chk("c1_addr",  imem.imem_addr, 32'h4);
    chk("c1_valid", {31'b0, valid_f}, 32'd0);
    chk("c1_busy",  {31'b0, fetch_busy}, 32'd1);
    @(negedge clk); #1;
    chk("c2_valid", {31'b0, valid_f}, 32'd1);
    chk("c2_pc",    pc_f, 32'h0);
    chk("c2_instr", instr_f, 32'hA000_0000);
    chk("c2_pc4",   pc_plus4_f, 32'h4);
    chk("c2_addr",  imem.imem_addr, 32'h8);
    @(negedge clk); #1;
    chk("c3_pc",    pc_f, 32'h4);
    chk("c3_instr", instr_f, 32'hA000_0004);
    chk("c3_pc4",   pc_plus4_f, 32'h8);
    @(negedge clk); #1;
    chk("c4_pc",    pc_f, 32'h8);

    // Stall for three cycles while the queue fills
    @(negedge clk); stall_f = 1'b1; #1;
    chk("c5_pc",    pc_f, 32'hC);
    chk("c5_instr", instr_f, 32'hA000_000C);
    @(negedge clk); #1;
    chk("c6_pc",    pc_f, 32'hC);
    chk("c6_req",   {31'b0, imem.imem_req}, 32'd1);
    @(negedge clk); #1;
    chk("c7_pc",    pc_f, 32'hC);
    chk("c7_instr", instr_f, 32'hA000_000C);
    chk("c7_req",   {31'b0, imem.imem_req}, 32'd0);
    @(negedge clk); stall_f = 1'b0; #1;
    chk("c8_pc",    pc_f, 32'hC);
    chk("c8_req",   {31'b0, imem.imem_req}, 32'd0);
    @(negedge clk); #1;
    chk("c9_pc",    pc_f, 32'h10);
    chk("c9_req",   {31'b0, imem.imem_req}, 32'd1);
    chk("c9_addr",  imem.imem_addr, 32'h1C);
    @(negedge clk); #1;
    chk("c10_pc",   pc_f, 32'h14);
    @(negedge clk); #1;
    chk("c11_pc",   pc_f, 32'h18);
    @(negedge clk); #1;
    chk("c12_pc",   pc_f, 32'h1C);
    chk("c12_instr", instr_f, 32'hA000_001C);

    // Redirect with three requests in flight on a 4-cycle memory
    lat = 4;
    do_reset();
    @(negedge clk); rst = 1'b0; #1;
    chk("r0_addr", imem.imem_addr, 32'h0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("r2_addr", imem.imem_addr, 32'h8);
    @(negedge clk); pc_src_e = 1'b1; pc_target_e = 32'h100; #1;
    chk("r3_req", {31'b0, imem.imem_req}, 32'd0);
    @(negedge clk); pc_src_e = 1'b0; #1;
    chk("r4_addr",  imem.imem_addr, 32'h100);
    chk("r4_req",   {31'b0, imem.imem_req}, 32'd1);
    chk("r4_valid", {31'b0, valid_f}, 32'd0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("r6_valid", {31'b0, valid_f}, 32'd0);
    @(negedge clk); #1;
    chk("r7_valid", {31'b0, valid_f}, 32'd0);
    @(negedge clk); #1;
    chk("r8_valid", {31'b0, valid_f}, 32'd0);
    chk("r8_req",   {31'b0, imem.imem_req}, 32'd0);
    @(negedge clk); #1;
    chk("r9_valid", {31'b0, valid_f}, 32'd1);
    chk("r9_pc",    pc_f, 32'h100);
    chk("r9_instr", instr_f, 32'hA000_0100);

    // Redirect coinciding with a response and a stall
    lat = 1;
    do_reset();
    @(negedge clk); rst = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); stall_f = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h200; #1;
    chk("s2_valid", {31'b0, valid_f}, 32'd1);
    chk("s2_pc",    pc_f, 32'h0);
    chk("s2_req",   {31'b0, imem.imem_req}, 32'd0);
    @(negedge clk); stall_f = 1'b0; pc_src_e = 1'b0; #1;
    chk("s3_valid", {31'b0, valid_f}, 32'd0);
    chk("s3_busy",  {31'b0, fetch_busy}, 32'd1);
    chk("s3_instr", instr_f, 32'h0000_0013);
    chk("s3_pc",    pc_f, 32'h0);
    chk("s3_addr",  imem.imem_addr, 32'h200);
    @(negedge clk); #1;
    chk("s4_valid", {31'b0, valid_f}, 32'd0);

    // Grant withheld for five cycles
    @(negedge clk); imem.imem_gnt = 1'b0; #1;
    chk("s5_pc",    pc_f, 32'h200);
    chk("s5_instr", instr_f, 32'hA000_0200);
    chk("s5_addr",  imem.imem_addr, 32'h208);
    @(negedge clk); #1;
    chk("s6_pc",    pc_f, 32'h204);
    chk("s6_addr",  imem.imem_addr, 32'h208);
    for (int i = 7; i <= 9; i++) begin
      @(negedge clk); #1;
      chk($sformatf("s%0d_valid", i), {31'b0, valid_f}, 32'd0);
      chk($sformatf("s%0d_req", i),   {31'b0, imem.imem_req}, 32'd1);
      chk($sformatf("s%0d_addr", i),  imem.imem_addr, 32'h208);
    end
    chk("s9_busy", {31'b0, fetch_busy}, 32'd1);
    @(negedge clk); imem.imem_gnt = 1'b1; #1;
    chk("s10_addr", imem.imem_addr, 32'h208);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("s12_valid", {31'b0, valid_f}, 32'd1);
    chk("s12_pc",    pc_f, 32'h208);
    chk("s12_instr", instr_f, 32'hA000_0208);

    // Address wrap at the top of the space
    do_reset();
    @(negedge clk); rst = 1'b0; pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC; #1;
    chk("t0_req", {31'b0, imem.imem_req}, 32'd0);
    @(negedge clk); pc_src_e = 1'b0; #1;
    chk("t1_addr", imem.imem_addr, 32'hFFFF_FFFC);
    chk("t1_req",  {31'b0, imem.imem_req}, 32'd1);
    @(negedge clk); #1;
    chk("t2_addr", imem.imem_addr, 32'h0);
    @(negedge clk); #1;
    chk("t3_pc",    pc_f, 32'hFFFF_FFFC);
    chk("t3_pc4",   pc_plus4_f, 32'h0);
    chk("t3_instr", instr_f, 32'h5FFF_FFFC);
    @(negedge clk); #1;
    chk("t4_pc",    pc_f, 32'h0);
    chk("t4_instr", instr_f, 32'hA000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
